// File: rtl/hamming_pkg.sv
// Shared definitions for the nibble-Hamming code: widths, syndrome codes,
// the per-nibble parity equations and the syndrome-to-correction map.
package hamming_pkg;

  localparam int NIB_W   = 4;
  localparam int PAR_W   = 3;
  localparam int COUNT_W = 16;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // Each single-bit error position yields its own non-zero syndrome.
  typedef enum logic [PAR_W-1:0] {
    SYN_NONE = 3'b000,
    SYN_P0   = 3'b001,
    SYN_P1   = 3'b010,
    SYN_D1   = 3'b011,
    SYN_P2   = 3'b100,
    SYN_D2   = 3'b101,
    SYN_D3   = 3'b110,
    SYN_D0   = 3'b111
  } syndrome_e;

  typedef struct packed {
    logic [NIB_W-1:0] flip;
    logic             par_fix;
  } syn_action_t;

  function automatic logic [PAR_W-1:0] nibble_parity(input logic [NIB_W-1:0] d);
    return {d[0] ^ d[2] ^ d[3],
            d[0] ^ d[1] ^ d[3],
            d[0] ^ d[1] ^ d[2]};
  endfunction

  function automatic syn_action_t syndrome_decode(input logic [PAR_W-1:0] s);
    syn_action_t act;
    act = '0;
    case (syndrome_e'(s))
      SYN_D0:                 act.flip    = 4'b0001;
      SYN_D1:                 act.flip    = 4'b0010;
      SYN_D2:                 act.flip    = 4'b0100;
      SYN_D3:                 act.flip    = 4'b1000;
      SYN_P0, SYN_P1, SYN_P2: act.par_fix = 1'b1;
      default:                act         = '0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/hamming_nibble_fix.sv
// Combinational single-nibble corrector: applies the syndrome to one data
// nibble and reports whether a data or a parity bit was at fault.
module hamming_nibble_fix
  import hamming_pkg::*;
(
  input  logic [NIB_W-1:0] d,
  input  logic [PAR_W-1:0] s,
  output logic [NIB_W-1:0] d_corr,
  output logic             data_fix,
  output logic             par_fix
);

  syn_action_t act;

  // NOTE: every output gets a value on every pass, so no latch is inferred.
  always_comb begin
    act      = syndrome_decode(s);
    d_corr   = d ^ act.flip;
    data_fix = |act.flip;
    par_fix  = act.par_fix;
  end

endmodule

// File: rtl/hamming_word_decoder.sv
// Two-stage nibble-Hamming word decoder with valid/ready on both sides.
// Define HAMMING_DEC_STATS_EN to build the saturating error counter.
module hamming_word_decoder
  import hamming_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int BLOCKS      = WIDTH / 4,
  parameter int PARITY_BITS = BLOCKS * 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [PARITY_BITS-1:0] in_parity,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [BLOCKS-1:0]      out_data_fix,
  output logic [BLOCKS-1:0]      out_par_fix,
  output logic                   out_error,
  input  logic                   clear_count,
  output logic [COUNT_W-1:0]     err_count
);

  logic                   s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]       s1_data_q,  s1_data_d;
  logic [PARITY_BITS-1:0] s1_syn_q,   s1_syn_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]       s2_data_q,  s2_data_d;
  logic [BLOCKS-1:0]      s2_dfix_q,  s2_dfix_d;
  logic [BLOCKS-1:0]      s2_pfix_q,  s2_pfix_d;

  logic [PARITY_BITS-1:0] syn_calc;
  logic [WIDTH-1:0]       fix_data;
  logic [BLOCKS-1:0]      fix_dfix;
  logic [BLOCKS-1:0]      fix_pfix;

  logic s2_load;
  logic s1_adv;
  logic in_fire;

  // Stage 2 frees up when empty or draining, which in turn lets stage 1 move.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_load;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    syn_calc = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      syn_calc[PAR_W*i +: PAR_W] = in_parity[PAR_W*i +: PAR_W]
                                 ^ nibble_parity(in_data[NIB_W*i +: NIB_W]);
    end
  end

  for (genvar g = 0; g < BLOCKS; g++) begin : g_fix
    hamming_nibble_fix u_fix (
      .d        (s1_data_q[NIB_W*g +: NIB_W]),
      .s        (s1_syn_q[PAR_W*g +: PAR_W]),
      .d_corr   (fix_data[NIB_W*g +: NIB_W]),
      .data_fix (fix_dfix[g]),
      .par_fix  (fix_pfix[g])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_syn_d   = s1_syn_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_syn_d   = syn_calc;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_dfix_d  = s2_dfix_q;
    s2_pfix_d  = s2_pfix_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = fix_data;
        s2_dfix_d = fix_dfix;
        s2_pfix_d = fix_pfix;
      end
    end
  end

  // NOTE: datapath flops are reset too, because the outputs must read zero in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_dfix_q  <= '0;
      s2_pfix_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_syn_q   <= s1_syn_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_dfix_q  <= s2_dfix_d;
      s2_pfix_q  <= s2_pfix_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_data     = s2_data_q;
  assign out_data_fix = s2_dfix_q;
  assign out_par_fix  = s2_pfix_q;
  assign out_error    = (|s2_dfix_q) || (|s2_pfix_q);

`ifdef HAMMING_DEC_STATS_EN
  logic               out_fire;
  logic [COUNT_W-1:0] err_count_q, err_count_d;

  assign out_fire = s2_valid_q && out_ready;

  // Clear wins over a same-cycle increment; the count sticks at its maximum.
  always_comb begin
    err_count_d = err_count_q;
    if (clear_count) begin
      err_count_d = '0;
    end else if (out_fire && out_error && (err_count_q != COUNT_MAX)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  logic stats_unused;
  assign stats_unused = clear_count;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_hamming_word_decoder.sv
// Self-checking bench for hamming_word_decoder: directed vector table, stall
// and reset sequences, and a randomized stream scored against a reference model.
module tb_hamming_word_decoder;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [23:0] in_parity;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_data_fix;
  logic [7:0]  out_par_fix;
  logic        out_error;
  logic        clear_count;
  logic [15:0] err_count;

  hamming_word_decoder #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_parity    (in_parity),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_data_fix (out_data_fix),
    .out_par_fix  (out_par_fix),
    .out_error    (out_error),
    .clear_count  (clear_count),
    .err_count    (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic [7:0]  dfix;
    logic [7:0]  pfix;
  } exp_t;

  function automatic logic [2:0] enc_nib(input logic [3:0] d);
    return {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
  endfunction

  function automatic logic [23:0] enc_word(input logic [31:0] d);
    logic [23:0] p;
    for (int i = 0; i < 8; i++) p[3*i +: 3] = enc_nib(d[4*i +: 4]);
    return p;
  endfunction

  // Find the single code bit whose flip explains the syndrome; if no data
  // bit does, the fault must lie in a parity bit.
  function automatic exp_t model(input logic [31:0] d, input logic [23:0] p);
    exp_t e;
    e.data = d;
    e.dfix = '0;
    e.pfix = '0;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] nd;
      logic [2:0] s;
      bit         found;
      nd    = d[4*i +: 4];
      s     = p[3*i +: 3] ^ enc_nib(nd);
      found = 1'b0;
      if (s != 3'b000) begin
        for (int b = 0; b < 4; b++) begin
          if (!found && ((enc_nib(nd ^ (4'b0001 << b)) ^ enc_nib(nd)) == s)) begin
            nd[b] = ~nd[b];
            found = 1'b1;
          end
        end
        if (found) e.dfix[i] = 1'b1;
        else       e.pfix[i] = 1'b1;
      end
      e.data[4*i +: 4] = nd;
    end
    return e;
  endfunction

  task automatic gen_word(output logic [31:0] d, output logic [23:0] p);
    logic [31:0] clean;
    clean = $urandom;
    d     = clean;
    p     = enc_word(clean);
    for (int i = 0; i < 8; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)      d[4*i + r]     = ~d[4*i + r];
      else if (r < 7) p[3*i + r - 4] = ~p[3*i + r - 4];
    end
  endtask

  // ---------------- scoreboard monitor (samples on falling edge) ----------------
  exp_t        q[$];
  exp_t        mon_e;
  int          occ      = 0;
  int          n_out    = 0;
  int          n_block  = 0;
  logic [15:0] exp_cnt  = '0;
  bit          mon_cmp  = 1'b0;
  bit          last_in_fire = 1'b0;
  bit          hold_prev = 1'b0;
  logic [31:0] hold_data;
  bit          m_in_fire, m_out_fire;

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      occ          = 0;
      exp_cnt      = '0;
      last_in_fire = 1'b0;
      hold_prev    = 1'b0;
    end else begin
      m_in_fire  = in_valid && in_ready;
      m_out_fire = out_valid && out_ready;
      if (mon_cmp) check("in_ready_vs_occupancy", in_ready, !(occ == 2 && !out_ready));
      if (!in_ready) n_block++;
      if (hold_prev) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, hold_data);
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      if (m_out_fire) begin
        if (q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          mon_e = q.pop_front();
          n_out++;
          if (mon_cmp) begin
            check("stream_data", out_data, mon_e.data);
            check("stream_dfix", out_data_fix, mon_e.dfix);
            check("stream_pfix", out_par_fix, mon_e.pfix);
            check("stream_err", out_error, (mon_e.dfix | mon_e.pfix) != 8'h00);
          end
`ifdef HAMMING_DEC_STATS_EN
          if (!clear_count && ((mon_e.dfix | mon_e.pfix) != 8'h00) && exp_cnt != 16'hFFFF)
            exp_cnt = exp_cnt + 16'd1;
`endif
        end
      end
`ifdef HAMMING_DEC_STATS_EN
      if (clear_count) exp_cnt = '0;
`endif
      if (m_in_fire) q.push_back(model(in_data, in_parity));
      occ          = occ + int'(m_in_fire) - int'(m_out_fire);
      last_in_fire = m_in_fire;
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] data;
    logic [23:0] par;
    logic [31:0] exp_data;
    logic [7:0]  exp_dfix;
    logic [7:0]  exp_pfix;
    logic        exp_err;
  } vec_t;

  vec_t tbl [7];

  task automatic run_vec(input int idx, input vec_t v);
    int waited;
    int lat;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_data   = v.data;
    in_parity = v.par;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 20);
    if (!in_ready) fail_now($sformatf("vec%0d_accept_timeout", idx));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check($sformatf("vec%0d_latency", idx), lat, 2);
    check($sformatf("vec%0d_data", idx), out_data, v.exp_data);
    check($sformatf("vec%0d_dfix", idx), out_data_fix, v.exp_dfix);
    check($sformatf("vec%0d_pfix", idx), out_par_fix, v.exp_pfix);
    check($sformatf("vec%0d_err", idx), out_error, v.exp_err);
  endtask

  // Drives n_words through the handshake; stall mode keeps input valid and
  // cycles out_ready through 1,0,0,1.
  task automatic stream(input int n_words, input bit stall_mode);
    int          sent;
    int          cyc;
    logic [31:0] d;
    logic [23:0] p;
    bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent = 0;
    cyc  = 0;
    while ((sent < n_words || in_valid || q.size() != 0) && cyc < 4000) begin
      @(posedge clk); #1;
      if (last_in_fire) begin
        sent++;
        in_valid = 1'b0;
      end
      if (!in_valid && sent < n_words && (stall_mode || $urandom_range(0, 3) != 0)) begin
        gen_word(d, p);
        in_data   = d;
        in_parity = p;
        in_valid  = 1'b1;
      end
      out_ready   = stall_mode ? pat[cyc % 4] : ($urandom_range(0, 9) < 7);
      clear_count = !stall_mode && ($urandom_range(0, 49) == 0);
      cyc++;
    end
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    clear_count = 1'b0;
    if (cyc >= 4000) fail_now("stream_timeout");
  endtask

  int out_base;
  int block_base;

  initial begin
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_parity   = '0;
    out_ready   = 1'b1;
    clear_count = 1'b0;

    tbl[0] = '{32'h1234_5678, enc_word(32'h1234_5678), 32'h1234_5678, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{32'h0000_0001, enc_word(32'h0000_0000), 32'h0000_0000, 8'h01, 8'h00, 1'b1};
    tbl[2] = '{32'h0000_0000, 24'h00_0001,             32'h0000_0000, 8'h00, 8'h01, 1'b1};
    tbl[3] = '{32'hFFFF_FFFF ^ 32'h8421_8421, enc_word(32'hFFFF_FFFF), 32'hFFFF_FFFF, 8'hFF, 8'h00, 1'b1};
    tbl[4] = '{32'hA5A5_A5A5, enc_word(32'hA5A5_A5A5) ^ 24'h80_0000, 32'hA5A5_A5A5, 8'h00, 8'h80, 1'b1};
    tbl[5] = '{32'hDEAD_BEEF ^ 32'h0000_4000, enc_word(32'hDEAD_BEEF) ^ 24'h01_0000, 32'hDEAD_BEEF, 8'h08, 8'h20, 1'b1};
    tbl[6] = '{32'h0000_0000, 24'h00_0000,             32'h0000_0000, 8'h00, 8'h00, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_dfix", out_data_fix, 8'h00);
    check("rst_pfix", out_par_fix, 8'h00);
    check("rst_err", out_error, 1'b0);
    check("rst_err_count", err_count, 16'h0);
    #2 reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);
    @(posedge clk); #2;
`ifdef HAMMING_DEC_STATS_EN
    check("table_err_count", err_count, 16'd5);
`else
    check("table_err_count", err_count, 16'd0);
`endif

    mon_cmp    = 1'b1;
    out_base   = n_out;
    block_base = n_block;
    stream(10, 1'b1);
    check("stall_delivered", n_out - out_base, 10);
    check("stall_backpressure_seen", (n_block - block_base) > 0, 1'b1);

    stream(300, 1'b0);
    @(posedge clk); #2;
    check("random_err_count", err_count, exp_cnt);

`ifdef HAMMING_DEC_STATS_EN
    out_ready = 1'b1;
    in_data   = 32'h0;
    in_parity = 24'h00_0001;
    in_valid  = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    check("sat_reached", err_count, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    check("sat_held", err_count, 16'hFFFF);
    clear_count = 1'b1;
    @(posedge clk); #1;
    clear_count = 1'b0;
    check("clear_over_increment", err_count, 16'h0);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("post_clear_count", err_count, exp_cnt);
`endif

    out_ready = 1'b1;
    in_data   = 32'h0000_0010;
    in_parity = enc_word(32'h0);
    in_valid  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_out_valid", out_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 32'h0);
    check("midrst_dfix", out_data_fix, 8'h00);
    check("midrst_err", out_error, 1'b0);
    check("midrst_err_count", err_count, 16'h0);
    check("midrst_in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_no_ghost", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_word_decoder.md
# hamming_word_decoder

Standalone decoder for the nibble-Hamming code used by the protected counter: per 4-bit data nibble, 3 stored parity bits. Accepts a data word plus stored parity over a valid/ready handshake, recomputes the syndrome, corrects any single-bit error per nibble (data or parity), and returns the corrected word with per-nibble correction flags. Sits on the readout side of the protected counter and serves any consumer reading protected words; it is a 2-stage pipeline with full throughput and backpressure.

## Interface
- WIDTH, 32, data word width; must be a multiple of 4
- BLOCKS, WIDTH/4, number of nibbles
- PARITY_BITS, BLOCKS*3, stored parity width

- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  input word valid
- in_ready  out  1  decoder can accept input
- in_data  in  WIDTH  stored data word
- in_parity  in  PARITY_BITS  stored parity, 3 bits per nibble
- out_valid  out  1  corrected word valid
- out_ready  in  1  consumer accepts output
- out_data  out  WIDTH  corrected data word
- out_data_fix  out  BLOCKS  bit i set: a data bit of nibble i was flipped
- out_par_fix  out  BLOCKS  bit i set: a parity bit of nibble i was flipped
- out_error  out  1  OR of out_data_fix and out_par_fix
- clear_count  in  1  synchronous clear of err_count
- err_count  out  16  count of accepted words with out_error set

## Operation
- Encoding per nibble i, d=data[4i+3:4i], p=parity[3i+2:3i]: p2=d0^d2^d3, p1=d0^d1^d3, p0=d0^d1^d2.
- Syndrome s=p^recomputed(d), 3 bits per nibble.
- Syndrome map: 000 no error; 111 flip d0; 011 flip d1; 101 flip d2; 110 flip d3; 001/010/100 parity bit 0/1/2 wrong (data unchanged, set par_fix).
- Double errors within a nibble alias to a single-bit correction; not detected. Nibbles are independent.
- Stage 1: capture in_data, in_parity, compute and register syndrome. Stage 2: register corrected data and flags.
- Handshake: transfer on valid&&ready at each interface. out_valid holds and out_data/flags stay stable until out_ready. Stage 2 loads when empty or out_ready; stage 1 advances when stage 2 loads; in_ready = !s1_valid || stage-1 advance.
- err_count increments by 1 when an output transfers with out_error=1; saturates at 16'hFFFF. clear_count has priority over increment in the same cycle.

## Timing
- Reset: in_ready=1 (after reset released, combinationally from empty pipe), out_valid=0, out_data=0, out_data_fix=0, out_par_fix=0, out_error=0, err_count=0, both stage valids 0.
- Latency: input accepted at edge N -> out_valid at edge N+2 (no stall).
- Throughput: one word per cycle with out_ready held high.
- Stall: out_ready low with both stages full -> in_ready low next cycle; no word dropped or duplicated.
- Reset mid-operation: in-flight words discarded, outputs return to reset values immediately (asynchronous).

## Configuration
- HAMMING_DEC_STATS_EN defined: err_count and clear_count behave as above.
- Not defined: counter logic removed, err_count tied to 0, clear_count ignored; ports remain.

## Structure
- Package hamming_pkg: nibble/parity width constants, function nibble_parity(d) returning 3 bits, enum/localparams for syndrome codes, function for syndrome decode.
- Sub-module hamming_nibble_fix: combinational per-nibble correction (d, s in -> corrected d, data_fix, par_fix), instantiated BLOCKS times in stage 2.

## Test plan
- Clean word data=32'h1234_5678 with correct parity -> out_data=32'h1234_5678, both fix masks 0, out_error=0, at cycle N+2.
- data=32'h0000_0001 with parity encoded for 32'h0 (nibble 0 d0 flipped, syndrome 111) -> out_data=32'h0, out_data_fix=8'h01, err_count=1.
- data=32'h0, parity=24'h000001 (nibble 0 p0 wrong) -> out_data=32'h0, out_par_fix=8'h01, out_data_fix=0, out_error=1.
- Single data-bit errors in all 8 nibbles at once on 32'hFFFF_FFFF -> all corrected, out_data_fix=8'hFF.
- 10 back-to-back words, out_ready toggled 1,0,0,1 pattern -> all 10 delivered in order, none lost, in_ready low only while both stages full.
- HAMMING_DEC_STATS_EN: force err_count to 16'hFFFF via errored stream -> stays saturated; clear_count with simultaneous error transfer -> err_count=0; reset_n pulse mid-stream -> out_valid=0 immediately.
